addsub_sequencer: RTL

ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

---
 rtl/addsub_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/addsub_sequencer.sv
// Sequences one add/subtract through an external 4-bit ripple adder: latch operands,
// wait SETTLE_CYCLES for the carry chain, capture result and flags, hold until consumed.
module addsub_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_mode,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_mode,
    input  logic [3:0] add_s,
    input  logic       add_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_s,
    output logic       out_cout,
    output logic       out_zero,
    output logic       out_ovf,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       accept, settle_done, handshake, ovf;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == HOLD);

    // Operand sign bits agree for add (differ for subtract) and the result sign flipped.
    assign ovf = ((add_a[3] ^ add_b[3]) == add_mode) && (add_s[3] != add_a[3]);

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        settle_done = 1'b0;
        handshake   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == LAST) begin
                    settle_done = 1'b1;
                    state_nx    = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_mode <= 1'b0;
            out_s    <= '0;
            out_cout <= 1'b0;
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
            op_count <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                add_a    <= in_a;
                add_b    <= in_b;
                add_mode <= in_mode;
                cnt      <= '0;
            end else if (state == SETTLE) begin
                cnt <= cnt + 4'd1;
            end
            if (settle_done) begin
                out_s    <= add_s;
                out_cout <= add_cout;
                out_zero <= (add_s == 4'd0);
                out_ovf  <= ovf;
            end
            if (handshake) op_count <= op_count + 8'd1;
        end
    end

endmodule
